// File: rtl/clock_ctrl_pkg.sv
// Shared state encoding and default widths for the CPU clock-enable sequencer.
package clock_ctrl_pkg;

   localparam int DIV_WIDTH_DEF   = 16;
   localparam int BURST_WIDTH_DEF = 16;

   typedef enum logic [1:0] {
      ST_HALT  = 2'd0,
      ST_RUN   = 2'd1,
      ST_STEP  = 2'd2,
      ST_BURST = 2'd3
   } state_e;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer for a raw asynchronous level, followed by a rising-edge
// detector that emits one single-cycle pulse per low-to-high transition.
module sync_edge (
   input  logic clk,
   input  logic rst,
   input  logic d_i,
   output logic pulse_o
);

   logic meta_q, sync_q, prev_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
         prev_q <= 1'b0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
         prev_q <= sync_q;
      end
   end

   assign pulse_o = sync_q & ~prev_q;

endmodule

// File: rtl/clock_controller.sv
// Run/halt/step/burst sequencer producing the single-cycle CPU clock enable
// `tick`, one per divided period, decoded purely from registered state.
module clock_controller
   import clock_ctrl_pkg::*;
#(
   parameter int DIV_WIDTH   = DIV_WIDTH_DEF,
   parameter int BURST_WIDTH = BURST_WIDTH_DEF
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   run_cmd,
   input  logic                   halt_cmd,
   input  logic                   burst_cmd,
   input  logic [BURST_WIDTH-1:0] burst_count,
   input  logic                   step_btn,
   input  logic [DIV_WIDTH-1:0]   divide,
   output logic                   tick,
   output logic [1:0]             state,
   output logic                   busy,
   output logic [BURST_WIDTH-1:0] remaining,
   output logic [31:0]            tick_total
);

   localparam logic [DIV_WIDTH-1:0]   DIV_ONE   = DIV_WIDTH'(1);
   localparam logic [BURST_WIDTH-1:0] BURST_ONE = BURST_WIDTH'(1);

   state_e                 state_q, state_d;
   logic [DIV_WIDTH-1:0]   div_q, div_d;
   logic [DIV_WIDTH-1:0]   cnt_q, cnt_d;
   logic [BURST_WIDTH-1:0] rem_q, rem_d;
   logic [31:0]            tick_total_q;
   logic                   step_pulse;
   logic                   tick_w;

   sync_edge u_step_sync (
      .clk     (clk),
      .rst     (rst),
      .d_i     (step_btn),
      .pulse_o (step_pulse)
   );

   // div_q >= 1 always, so div_q-1 never underflows
   assign tick_w = (state_q != ST_HALT) && (cnt_q == div_q - DIV_ONE);

   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      case (state_q)
         ST_HALT: begin
            if (halt_cmd) begin
               state_d = ST_HALT;
            end else if (run_cmd) begin
               state_d = ST_RUN;
            end else if (burst_cmd && (burst_count != '0)) begin
               state_d = ST_BURST;
               rem_d   = burst_count;
            end else if (step_pulse) begin
               state_d = ST_STEP;
            end
         end
         ST_RUN: begin
            if (halt_cmd) state_d = ST_HALT;
         end
         ST_STEP: begin
            if (tick_w || halt_cmd) state_d = ST_HALT;
         end
         ST_BURST: begin
            if (halt_cmd) begin
               state_d = ST_HALT;
               rem_d   = '0;
            end else if (tick_w) begin
               rem_d = rem_q - BURST_ONE;
               if (rem_q == BURST_ONE) state_d = ST_HALT;
            end
         end
      endcase
   end

   // Period is only sampled while halted so a running CPU sees a stable rate
   assign div_d = (state_q != ST_HALT) ? div_q :
                  (divide == '0)       ? DIV_ONE : divide;

   assign cnt_d = (state_q == ST_HALT || state_d == ST_HALT || tick_w) ? '0
                                                                       : cnt_q + DIV_ONE;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_HALT;
         div_q        <= DIV_ONE;
         cnt_q        <= '0;
         rem_q        <= '0;
         tick_total_q <= '0;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         cnt_q   <= cnt_d;
         rem_q   <= rem_d;
         if (tick_w) tick_total_q <= tick_total_q + 32'd1;
      end
   end

   assign tick       = tick_w;
   assign state      = state_q;
   assign busy       = (state_q != ST_HALT);
   assign remaining  = rem_q;
   assign tick_total = tick_total_q;

endmodule

// File: tb/tb_clock_controller.sv
// Directed bench for clock_controller: per-cycle vector tables for run/halt and
// burst sequences, plus hand-written step, priority, abort, reset and wrap cases.
module tb_clock_controller;

   logic        clk = 1'b0;
   logic        rst;
   logic        run_cmd, halt_cmd, burst_cmd, step_btn;
   logic [15:0] burst_count, divide;
   logic        tick, busy;
   logic [1:0]  state;
   logic [15:0] remaining;
   logic [31:0] tick_total;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic        run, halt, burst;
      logic [15:0] bcnt, div;
      logic        exp_tick;
      logic [1:0]  exp_state;
      logic [15:0] exp_rem;
      logic [31:0] exp_total;
   } vec_t;

   vec_t vecs[$];

   clock_controller #(.DIV_WIDTH(16), .BURST_WIDTH(16)) dut (
      .clk         (clk),
      .rst         (rst),
      .run_cmd     (run_cmd),
      .halt_cmd    (halt_cmd),
      .burst_cmd   (burst_cmd),
      .burst_count (burst_count),
      .step_btn    (step_btn),
      .divide      (divide),
      .tick        (tick),
      .state       (state),
      .busy        (busy),
      .remaining   (remaining),
      .tick_total  (tick_total)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic next_cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic clr_cmds();
      run_cmd = 1'b0; halt_cmd = 1'b0; burst_cmd = 1'b0;
   endtask

   // Leaves the bench 1 time unit after an edge, in cycle 0
   task automatic do_reset(input logic [15:0] div);
      rst = 1'b1;
      clr_cmds();
      burst_count = '0; step_btn = 1'b0; divide = div;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic apply_table(input string tag);
      for (int i = 0; i < vecs.size(); i++) begin
         run_cmd = vecs[i].run; halt_cmd = vecs[i].halt; burst_cmd = vecs[i].burst;
         burst_count = vecs[i].bcnt; divide = vecs[i].div;
         #1;
         chk($sformatf("%s_tick_c%0d", tag, i), 32'(tick), 32'(vecs[i].exp_tick));
         chk($sformatf("%s_state_c%0d", tag, i), 32'(state), 32'(vecs[i].exp_state));
         chk($sformatf("%s_busy_c%0d", tag, i), 32'(busy), 32'(vecs[i].exp_state != 2'd0));
         chk($sformatf("%s_rem_c%0d", tag, i), 32'(remaining), 32'(vecs[i].exp_rem));
         chk($sformatf("%s_total_c%0d", tag, i), tick_total, vecs[i].exp_total);
         next_cyc();
      end
      clr_cmds();
      vecs.delete();
   endtask

   initial begin
      vec_t v;
      int   nt, first_step, first_tick;
      logic [31:0] mask;

      // Run/halt at divide=4: run@10, halt@20, run@25, halt@30
      for (int c = 0; c <= 30; c++) begin
         v.run = (c == 10 || c == 25); v.halt = (c == 20 || c == 30); v.burst = 1'b0;
         v.bcnt = 16'd0; v.div = 16'd4;
         v.exp_tick  = (c == 14 || c == 18 || c == 29);
         v.exp_state = ((c >= 11 && c <= 20) || c >= 26) ? 2'd1 : 2'd0;
         v.exp_rem   = 16'd0;
         v.exp_total = (c <= 14) ? 32'd0 : (c <= 18) ? 32'd1 : (c <= 29) ? 32'd2 : 32'd3;
         vecs.push_back(v);
      end
      do_reset(16'd4);
      chk("reset_state", 32'(state), 32'd0);
      chk("reset_tick", 32'(tick), 32'd0);
      chk("reset_total", tick_total, 32'd0);
      apply_table("runhalt");

      // Burst of 3 at divide=2 issued at 5; zero-count burst at 14 is ignored
      for (int c = 0; c <= 17; c++) begin
         v.run = 1'b0; v.halt = 1'b0; v.burst = (c == 5 || c == 14);
         v.bcnt = (c == 5) ? 16'd3 : (c == 14) ? 16'd0 : 16'd7; v.div = 16'd2;
         v.exp_tick  = (c == 7 || c == 9 || c == 11);
         v.exp_state = (c >= 6 && c <= 11) ? 2'd3 : 2'd0;
         v.exp_rem   = (c >= 6 && c <= 7) ? 16'd3 : (c >= 8 && c <= 9) ? 16'd2 :
                       (c >= 10 && c <= 11) ? 16'd1 : 16'd0;
         v.exp_total = (c <= 7) ? 32'd0 : (c <= 9) ? 32'd1 : (c <= 11) ? 32'd2 : 32'd3;
         vecs.push_back(v);
      end
      do_reset(16'd2);
      apply_table("burst");

      // Held step button at divide=3: one pulse, STEP from cycle 3, tick at 5
      do_reset(16'd3);
      step_btn = 1'b1;
      nt = 0; first_step = -1; first_tick = -1;
      for (int k = 0; k < 50; k++) begin
         #1;
         if (tick) begin
            nt++;
            if (first_tick < 0) first_tick = k;
         end
         if (state == 2'd2 && first_step < 0) first_step = k;
         next_cyc();
      end
      chk("step_ticks", 32'(nt), 32'd1);
      chk("step_first_state", 32'(first_step), 32'd3);
      chk("step_tick_cycle", 32'(first_tick), 32'd5);
      chk("step_end_state", 32'(state), 32'd0);
      step_btn = 1'b0;
      repeat (5) next_cyc();
      step_btn = 1'b1;
      nt = 0;
      for (int k = 0; k < 20; k++) begin
         #1;
         if (tick) nt++;
         next_cyc();
      end
      chk("step_second_ticks", 32'(nt), 32'd1);
      chk("step_total", tick_total, 32'd2);

      // run + burst + step_pulse together in HALT: run wins
      do_reset(16'd4);
      step_btn = 1'b1;
      next_cyc();
      next_cyc();
      run_cmd = 1'b1; burst_cmd = 1'b1; burst_count = 16'd5;
      next_cyc();
      clr_cmds();
      #1;
      chk("prio_run_state", 32'(state), 32'd1);
      chk("prio_run_rem", 32'(remaining), 32'd0);
      halt_cmd = 1'b1;
      next_cyc();
      run_cmd = 1'b1;
      next_cyc();
      clr_cmds();
      #1;
      chk("prio_halt_over_run", 32'(state), 32'd0);
      step_btn = 1'b0;

      // divide change mid-run is deferred until after the next halt
      do_reset(16'd4);
      mask = '0;
      for (int k = 0; k <= 17; k++) begin
         clr_cmds();
         if (k == 1) divide = 16'd2;
         run_cmd  = (k == 0 || k == 12);
         halt_cmd = (k == 9 || k == 17);
         #1;
         if (tick) mask[k] = 1'b1;
         if (k == 10) chk("divchg_halted", 32'(state), 32'd0);
         next_cyc();
      end
      clr_cmds();
      chk("divchg_tick_mask", mask, 32'h0001_4110);
      chk("divchg_total", tick_total, 32'd4);

      // Abort a 10-tick burst after 4 ticks
      do_reset(16'd2);
      burst_cmd = 1'b1; burst_count = 16'd10;
      repeat (9) begin
         next_cyc();
         clr_cmds();
      end
      #1;
      chk("abort_rem_before", 32'(remaining), 32'd6);
      halt_cmd = 1'b1;
      next_cyc();
      clr_cmds();
      #1;
      chk("abort_state", 32'(state), 32'd0);
      chk("abort_rem", 32'(remaining), 32'd0);
      chk("abort_total", tick_total, 32'd4);

      // divide=0 acts as 1: continuous ticks, then tick_total wrap, then async reset
      do_reset(16'd0);
      run_cmd = 1'b1;
      next_cyc();
      clr_cmds();
      nt = 0;
      for (int k = 1; k <= 5; k++) begin
         #1;
         if (tick) nt++;
         next_cyc();
      end
      chk("div0_continuous", 32'(nt), 32'd5);
      chk("div0_total", tick_total, 32'd5);
      force dut.tick_total_q = 32'hFFFF_FFFF;
      #1 release dut.tick_total_q;
      #1;
      chk("wrap_preload", tick_total, 32'hFFFF_FFFF);
      next_cyc();
      chk("wrap_zero", tick_total, 32'd0);
      chk("wrap_still_run", 32'(state), 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_state", 32'(state), 32'd0);
      chk("async_rst_tick", 32'(tick), 32'd0);
      chk("async_rst_busy", 32'(busy), 32'd0);
      chk("async_rst_total", tick_total, 32'd0);
      chk("async_rst_rem", 32'(remaining), 32'd0);
      next_cyc();
      rst = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
